// File: rtl/sram_if.sv
// Write/read bus between a buffer producer/consumer and the dual-port sram.
// One write port and one registered read port, both usable in the same cycle.
interface sram_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 15
);
   logic                  write_en;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [DATA_WIDTH-1:0] write_data;
   logic [ADDR_WIDTH-1:0] read_addr;
   logic [DATA_WIDTH-1:0] read_data;

   modport master (
      output write_en,
      output write_addr,
      output write_data,
      output read_addr,
      input  read_data
   );

   modport slave (
      input  write_en,
      input  write_addr,
      input  write_data,
      input  read_addr,
      output read_data
   );
endinterface

// File: rtl/sram.sv
// Simple dual-port synchronous SRAM with write-first bypass and a per-word valid
// bitmap so never-written locations read as zero after reset.
module sram #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 15
) (
   input logic  clk,
   input logic  rst_n,
   sram_if.slave bus
);
   localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
   logic [RAM_DEPTH-1:0]  valid_q;
   logic [DATA_WIDTH-1:0] read_data_q;
   logic [DATA_WIDTH-1:0] read_sel;
   logic                  bypass;

   // Array contents are never reset; the valid bitmap hides stale words instead.
   always_ff @(posedge clk) begin
      if (rst_n && bus.write_en) begin
         mem[bus.write_addr] <= bus.write_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (bus.write_en) begin
         valid_q[bus.write_addr] <= 1'b1;
      end
   end

   assign bypass = bus.write_en && (bus.write_addr == bus.read_addr);

   always_comb begin
      read_sel = '0;
      if (bypass) begin
         read_sel = bus.write_data;
      end else if (valid_q[bus.read_addr]) begin
         read_sel = mem[bus.read_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_data_q <= '0;
      end else begin
         read_data_q <= read_sel;
      end
   end

   assign bus.read_data = read_data_q;
endmodule

// File: tb/tb_sram.sv
// Directed self-checking bench for sram: fill/readback, write-disable, bypass,
// reset clearing, boundary addresses and concurrent independent ports.
module tb_sram;
   logic clk;
   logic rst_n;
   int   passed;
   int   total;

   sram_if #(.DATA_WIDTH(16), .ADDR_WIDTH(15)) bus ();

   sram #(.DATA_WIDTH(16), .ADDR_WIDTH(15)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input int waddr, input int wdata, input int raddr);
      bus.write_en   = we;
      bus.write_addr = 15'(waddr);
      bus.write_data = 16'(wdata);
      bus.read_addr  = 15'(raddr);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 0, 0, 0);
      step();
      step();
      total++;
      if (bus.read_data !== 16'h0000)
         $display("FAIL reset_value: got %h want 0000", bus.read_data);
      else passed++;
      rst_n = 1'b1;
      drive(1'b0, 0, 0, 3);
      step();
      total++;
      if (bus.read_data !== 16'h0000)
         $display("FAIL unwritten_after_reset: got %h want 0000", bus.read_data);
      else passed++;
   endtask

   task automatic test_fill();
      for (int i = 0; i <= 256; i++) begin
         drive(i < 256, i, i, (i == 0) ? 0 : i - 1);
         step();
         if (i > 0) begin
            total++;
            if (bus.read_data !== 16'(i - 1))
               $display("FAIL fill_read[%0d]: got %h want %h", i - 1, bus.read_data, 16'(i - 1));
            else passed++;
         end
      end
   endtask

   task automatic test_write_disable();
      int addrs[4] = '{5, 10, 123, 36};
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, addrs[k], 255, addrs[k]);
         step();
         total++;
         if (bus.read_data !== 16'(addrs[k]))
            $display("FAIL wdis_read[%0d]: got %h want %h", addrs[k], bus.read_data,
                     16'(addrs[k]));
         else passed++;
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 0, 0, addrs[k]);
         step();
         total++;
         if (bus.read_data !== 16'(addrs[k]))
            $display("FAIL wdis_hold[%0d]: got %h want %h", addrs[k], bus.read_data,
                     16'(addrs[k]));
         else passed++;
      end
   endtask

   task automatic test_descending();
      for (int j = 255; j >= -1; j--) begin
         drive(j >= 0, (j >= 0) ? j : 0, (j >= 0) ? j : 0, (j == 255) ? 255 : j + 1);
         step();
         if (j < 255) begin
            total++;
            if (bus.read_data !== 16'(j + 1))
               $display("FAIL desc_read[%0d]: got %h want %h", j + 1, bus.read_data, 16'(j + 1));
            else passed++;
         end
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 50, 16'hA5A5, 50);
      step();
      total++;
      if (bus.read_data !== 16'hA5A5)
         $display("FAIL bypass: got %h want a5a5", bus.read_data);
      else passed++;
      drive(1'b0, 0, 0, 50);
      step();
      total++;
      if (bus.read_data !== 16'hA5A5)
         $display("FAIL bypass_stored: got %h want a5a5", bus.read_data);
      else passed++;
      drive(1'b1, 30, 16'h1111, 0);
      step();
      drive(1'b1, 30, 16'h2222, 0);
      step();
      drive(1'b0, 0, 0, 30);
      step();
      total++;
      if (bus.read_data !== 16'h2222)
         $display("FAIL last_write_wins: got %h want 2222", bus.read_data);
      else passed++;
   endtask

   task automatic test_reset_clear();
      drive(1'b1, 7, 16'h1234, 0);
      step();
      drive(1'b0, 0, 0, 7);
      step();
      total++;
      if (bus.read_data !== 16'h1234)
         $display("FAIL pre_reset_read: got %h want 1234", bus.read_data);
      else passed++;
      // Assert reset mid-cycle while a write is pending; it must be discarded.
      drive(1'b1, 9, 16'h9999, 7);
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.read_data !== 16'h0000)
         $display("FAIL reset_async: got %h want 0000", bus.read_data);
      else passed++;
      step();
      step();
      rst_n = 1'b1;
      drive(1'b0, 0, 0, 7);
      step();
      total++;
      if (bus.read_data !== 16'h0000)
         $display("FAIL reset_cleared_7: got %h want 0000", bus.read_data);
      else passed++;
      drive(1'b0, 0, 0, 9);
      step();
      total++;
      if (bus.read_data !== 16'h0000)
         $display("FAIL write_in_reset: got %h want 0000", bus.read_data);
      else passed++;
      drive(1'b0, 0, 0, 100);
      step();
      total++;
      if (bus.read_data !== 16'h0000)
         $display("FAIL reset_cleared_100: got %h want 0000", bus.read_data);
      else passed++;
      drive(1'b1, 7, 16'h5678, 0);
      step();
      drive(1'b0, 0, 0, 7);
      step();
      total++;
      if (bus.read_data !== 16'h5678)
         $display("FAIL rewrite_after_reset: got %h want 5678", bus.read_data);
      else passed++;
   endtask

   task automatic test_boundary();
      drive(1'b1, 15'h7FFF, 16'hFFFF, 1);
      step();
      drive(1'b1, 0, 16'h0001, 2);
      step();
      drive(1'b0, 0, 0, 15'h7FFF);
      step();
      total++;
      if (bus.read_data !== 16'hFFFF)
         $display("FAIL boundary_top: got %h want ffff", bus.read_data);
      else passed++;
      drive(1'b0, 0, 0, 0);
      step();
      total++;
      if (bus.read_data !== 16'h0001)
         $display("FAIL boundary_zero: got %h want 0001", bus.read_data);
      else passed++;
      drive(1'b0, 0, 0, 15'h4000);
      step();
      total++;
      if (bus.read_data !== 16'h0000)
         $display("FAIL unwritten_4000: got %h want 0000", bus.read_data);
      else passed++;
   endtask

   task automatic test_concurrent();
      drive(1'b1, 21, 16'h0015, 0);
      step();
      drive(1'b1, 20, 16'hBEEF, 21);
      step();
      total++;
      if (bus.read_data !== 16'h0015)
         $display("FAIL concurrent_old: got %h want 0015", bus.read_data);
      else passed++;
      drive(1'b0, 0, 0, 20);
      step();
      total++;
      if (bus.read_data !== 16'hBEEF)
         $display("FAIL concurrent_new: got %h want beef", bus.read_data);
      else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_fill();
      test_write_disable();
      test_descending();
      test_back_to_back();
      test_reset_clear();
      test_boundary();
      test_concurrent();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
